// File: rtl/reg_gate_sequencer.sv
// Timed gate sequencer for the inputa/inputb passthrough.
// Trigger -> delay -> gate open -> holdoff, repeated per arm.
module reg_gate_sequencer #(
    parameter int CNT_W       = 32,
    parameter int CNT_PULSE_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [15:0]      inputa,
    input  logic signed [15:0]      inputb,
    input  logic                    exttrig,
    input  logic                    cfg_enable,
    input  logic                    cfg_arm,
    input  logic                    cfg_sw_trig,
    input  logic [CNT_W-1:0]        cfg_delay,
    input  logic [CNT_W-1:0]        cfg_width,
    input  logic [CNT_W-1:0]        cfg_holdoff,
    input  logic [CNT_PULSE_W-1:0]  cfg_count,
    input  logic [1:0]              cfg_mask,
    output logic signed [15:0]      outputa,
    output logic signed [15:0]      outputb,
    output logic                    gate,
    output logic [2:0]              state_o,
    output logic [CNT_PULSE_W-1:0]  pulses_done,
    output logic [CNT_PULSE_W-1:0]  missed_trig
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_OPEN    = 3'd3,
        S_HOLDOFF = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
    localparam logic [CNT_PULSE_W-1:0] PC_ONE  = CNT_PULSE_W'(1);

    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [CNT_W-1:0]       width_eff;
    logic [CNT_PULSE_W-1:0] pd_n;
    logic [CNT_PULSE_W-1:0] pd_inc;
    logic [CNT_PULSE_W-1:0] miss_n;
    logic                   ext_q;
    logic                   arm_q;
    logic                   sw_q;
    logic                   arm_e;
    logic                   trig;
    logic                   busy;

    assign arm_e     = cfg_arm & ~arm_q;
    assign trig      = (exttrig & ~ext_q) | (cfg_sw_trig & ~sw_q);
    assign width_eff = (cfg_width == '0) ? CNT_ONE : cfg_width;
    assign pd_inc    = pulses_done + PC_ONE;
    assign busy      = (state == S_DELAY) || (state == S_OPEN) ||
                       (state == S_HOLDOFF);
    assign gate      = (state == S_OPEN);
    assign state_o   = state;

    // Next-state, counter reload and status counter updates
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pd_n    = pulses_done;
        miss_n  = missed_trig;
        if (!cfg_enable) begin
            state_n = S_IDLE;
        end else if (arm_e) begin
            state_n = S_ARMED;
            pd_n    = '0;
            miss_n  = '0;
        end else begin
            if (trig && busy && !(&missed_trig))
                miss_n = missed_trig + PC_ONE;
            unique case (state)
                S_ARMED: begin
                    if (trig) begin
                        if (cfg_delay == '0) begin
                            state_n = S_OPEN;
                            cnt_n   = width_eff;
                        end else begin
                            state_n = S_DELAY;
                            cnt_n   = cfg_delay;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt == CNT_ONE) begin
                        state_n = S_OPEN;
                        cnt_n   = width_eff;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                S_OPEN: begin
                    if (cnt == CNT_ONE) begin
                        pd_n = pd_inc;
                        if (cfg_count != '0 && pd_inc == cfg_count) begin
                            state_n = S_DONE;
                        end else if (cfg_holdoff == '0) begin
                            state_n = S_ARMED;
                        end else begin
                            state_n = S_HOLDOFF;
                            cnt_n   = cfg_holdoff;
                        end
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == CNT_ONE)
                        state_n = S_ARMED;
                    else
                        cnt_n = cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // State, counters, edge history and gated sample registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pulses_done <= '0;
            missed_trig <= '0;
            ext_q       <= 1'b0;
            arm_q       <= 1'b0;
            sw_q        <= 1'b0;
            outputa     <= '0;
            outputb     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pulses_done <= pd_n;
            missed_trig <= miss_n;
            ext_q       <= exttrig;
            arm_q       <= cfg_arm;
            sw_q        <= cfg_sw_trig;
            outputa     <= (gate && cfg_mask[0]) ? inputa : '0;
            outputb     <= (gate && cfg_mask[1]) ? inputb : '0;
        end
    end

endmodule

// File: tb/tb_reg_gate_sequencer.sv
// Bench for reg_gate_sequencer: timestamp-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_reg_gate_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] ina, inb;
    logic        ext, en, arm, sw;
    logic [31:0] dly, wid, hold;
    logic [15:0] cnt;
    logic [1:0]  mask;
    logic [15:0] outa, outb;
    logic        gate;
    logic [2:0]  st;
    logic [15:0] pd, miss;

    reg_gate_sequencer #(.CNT_W(32), .CNT_PULSE_W(16)) dut (
        .clk(clk), .reset(rst), .inputa(ina), .inputb(inb),
        .exttrig(ext), .cfg_enable(en), .cfg_arm(arm),
        .cfg_sw_trig(sw), .cfg_delay(dly), .cfg_width(wid),
        .cfg_holdoff(hold), .cfg_count(cnt), .cfg_mask(mask),
        .outputa(outa), .outputb(outb), .gate(gate),
        .state_o(st), .pulses_done(pd), .missed_trig(miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: phase boundaries kept as absolute cycle numbers
    longint      cyc;
    longint      t_open, t_oend, t_hend;
    int          m_state;
    logic [15:0] m_pd, m_miss, m_outa, m_outb;
    logic        m_ext_q, m_arm_q, m_sw_q;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pd = '0;
        m_miss = '0;
        m_outa = '0;
        m_outb = '0;
        m_ext_q = 1'b0;
        m_arm_q = 1'b0;
        m_sw_q = 1'b0;
    endtask

    task automatic model_step();
        bit          ae, tg, busy;
        logic [15:0] np;
        longint      w;
        if (rst) begin
            model_reset();
            return;
        end
        ae = arm && !m_arm_q;
        tg = (ext && !m_ext_q) || (sw && !m_sw_q);
        w  = (wid == 0) ? 1 : longint'(wid);
        m_outa = (m_state == 3 && mask[0]) ? ina : 16'h0;
        m_outb = (m_state == 3 && mask[1]) ? inb : 16'h0;
        m_ext_q = ext;
        m_arm_q = arm;
        m_sw_q  = sw;
        if (!en) begin
            m_state = 0;
        end else if (ae) begin
            m_state = 1;
            m_pd = '0;
            m_miss = '0;
        end else begin
            busy = (m_state >= 2 && m_state <= 4);
            if (tg && busy && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
            case (m_state)
                1: if (tg) begin
                    t_open = cyc + 1 + longint'(dly);
                    if (dly == 0) begin
                        m_state = 3;
                        t_oend = cyc + w;
                    end else begin
                        m_state = 2;
                    end
                end
                2: if (cyc + 1 == t_open) begin
                    m_state = 3;
                    t_oend = cyc + w;
                end
                3: if (cyc == t_oend) begin
                    np = m_pd + 16'd1;
                    m_pd = np;
                    if (cnt != 0 && np == cnt) m_state = 5;
                    else if (hold == 0) m_state = 1;
                    else begin
                        m_state = 4;
                        t_hend = cyc + longint'(hold);
                    end
                end
                4: if (cyc == t_hend) m_state = 1;
                default: ;
            endcase
        end
    endtask

    // one clock: compare DUT to model mid-cycle, advance model and DUT
    task automatic step();
        @(negedge clk);
        chk("state", 64'(st), 64'(m_state));
        chk("gate", 64'(gate), 64'(m_state == 3));
        chk("outa", 64'(outa), 64'(m_outa));
        chk("outb", 64'(outb), 64'(m_outb));
        chk("pulses", 64'(pd), 64'(m_pd));
        chk("missed", 64'(miss), 64'(m_miss));
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic arm_seq();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
    endtask

    task automatic set_cfg(input int d, input int w, input int h,
                           input int c, input int m);
        dly = d;
        wid = w;
        hold = h;
        cnt = 16'(c);
        mask = 2'(m);
    endtask

    initial begin
        int ng, first;
        cyc = 0;
        t_open = 0;
        t_oend = 0;
        t_hend = 0;
        rst = 1'b1;
        en = 1'b1;
        arm = 1'b0;
        sw = 1'b0;
        ext = 1'b0;
        ina = 16'h1234;
        inb = 16'h0BCD;
        set_cfg(3, 4, 0, 1, 3);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_state", 64'(st), 64'd0);
        chk("rst_gate", 64'(gate), 64'd0);
        chk("rst_outa", 64'(outa), 64'd0);
        chk("rst_pd", 64'(pd), 64'd0);
        chk("rst_miss", 64'(miss), 64'd0);
        rst = 1'b0;

        // basic pulse
        arm_seq();
        ext = 1'b1;
        step();
        ext = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk("basic_gate", 64'(gate), 64'(k >= 4 && k <= 7));
            chk("basic_outa", 64'(outa),
                (k >= 5 && k <= 8) ? 64'h1234 : 64'h0);
            chk("basic_outb", 64'(outb),
                (k >= 5 && k <= 8) ? 64'h0BCD : 64'h0);
            step();
        end
        chk("basic_done", 64'(st), 64'd5);
        chk("basic_pd", 64'(pd), 64'd1);

        // zero delay and width, two sw triggers
        set_cfg(0, 0, 0, 2, 3);
        arm_seq();
        sw = 1'b1;
        step();
        sw = 1'b0;
        chk("zero_g1", 64'(gate), 64'd1);
        step();
        chk("zero_g1_off", 64'(gate), 64'd0);
        chk("zero_armed", 64'(st), 64'd1);
        repeat (3) step();
        sw = 1'b1;
        step();
        sw = 1'b0;
        chk("zero_g2", 64'(gate), 64'd1);
        chk("zero_pd1", 64'(pd), 64'd1);
        step();
        chk("zero_done", 64'(st), 64'd5);
        chk("zero_pd2", 64'(pd), 64'd2);

        // missed triggers
        set_cfg(10, 10, 0, 1, 3);
        arm_seq();
        ext = 1'b1;
        step();
        ng = 0;
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            ext = (k == 3 || k == 12);
            if (gate) begin
                ng++;
                if (first < 0) first = k;
            end
            step();
        end
        ext = 1'b0;
        chk("miss_gates", 64'(ng), 64'd10);
        chk("miss_first", 64'(first), 64'd11);
        chk("miss_cnt", 64'(miss), 64'd2);
        chk("miss_done", 64'(st), 64'd5);

        // mask and abort
        set_cfg(0, 20, 0, 1, 2);
        ina = 16'h1111;
        inb = 16'hFFFB;
        arm_seq();
        ext = 1'b1;
        step();
        ext = 1'b0;
        chk("mask_gate", 64'(gate), 64'd1);
        step();
        chk("mask_outa", 64'(outa), 64'd0);
        chk("mask_outb", 64'(outb), 64'hFFFB);
        en = 1'b0;
        step();
        chk("abort_state", 64'(st), 64'd0);
        chk("abort_outb_hold", 64'(outb), 64'hFFFB);
        step();
        chk("abort_outb", 64'(outb), 64'd0);
        en = 1'b1;
        step();
        chk("abort_idle", 64'(st), 64'd0);

        // unlimited with holdoff
        set_cfg(2, 2, 5, 0, 3);
        arm_seq();
        for (int i = 0; i < 4; i++) begin
            ext = 1'b1;
            step();
            for (int k = 1; k <= 19; k++) begin
                ext = (i == 1 && k == 4);
                step();
            end
            ext = 1'b0;
            chk("unl_armed", 64'(st), 64'd1);
            chk("unl_pd", 64'(pd), 64'(i + 1));
        end
        chk("unl_missed", 64'(miss), 64'd1);
        arm = 1'b1;
        ext = 1'b1;
        step();
        arm = 1'b0;
        ext = 1'b0;
        chk("armtrig_state", 64'(st), 64'd1);
        chk("armtrig_miss", 64'(miss), 64'd0);
        chk("armtrig_pd", 64'(pd), 64'd0);
        ng = 0;
        for (int k = 0; k < 6; k++) begin
            if (gate) ng++;
            step();
        end
        chk("armtrig_nogate", 64'(ng), 64'd0);

        // reset mid-OPEN
        set_cfg(0, 10, 0, 1, 3);
        arm_seq();
        ext = 1'b1;
        step();
        ext = 1'b0;
        step();
        ext = 1'b1;
        step();
        ext = 1'b0;
        chk("pre_rst_gate", 64'(gate), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_state", 64'(st), 64'd0);
        chk("mrst_gate", 64'(gate), 64'd0);
        chk("mrst_outa", 64'(outa), 64'd0);
        chk("mrst_outb", 64'(outb), 64'd0);
        chk("mrst_pd", 64'(pd), 64'd0);
        chk("mrst_miss", 64'(miss), 64'd0);

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 799) == 0);
            en  = ($urandom_range(0, 199) != 0);
            arm = ($urandom_range(0, 39) == 0);
            ext = ($urandom_range(0, 5) == 0);
            sw  = ($urandom_range(0, 24) == 0);
            ina = 16'($urandom);
            inb = 16'($urandom);
            if ($urandom_range(0, 29) == 0)
                set_cfg($urandom_range(0, 6), $urandom_range(0, 5),
                        $urandom_range(0, 4), $urandom_range(0, 3),
                        $urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
